ts4231_bus_responder: RTL and testbench
=======================================

Name: ts4231_bus_responder

Overview:
- Synthesizable model of the TS4231 light-sensor side of the two-wire D/E bus. It is the responder to our D/E configuration master.
- Emulates power-up light detection, accepts configuration write frames, serves configuration read-back frames, and enters the watch state, where it drives envelope pulses.
- Used on the test board and in benches, standing in for a real sensor when closing the loop on the lighthouse tracking front end.

Parameters:
- DEFAULT_CFG, 15'h0000: cfg_word value after reset or chip reset.
- LIGHT_SWAPS, 4: number of light pulses echoed on D before the bus is released to configuration.

Ports:
- clock  in  1  system clock
- reset  in  1  reset; synchronous, active-low
- chip_rst_n  in  1  sensor hard reset from the master; active-low
- d_in  in  1  D pad level (asynchronous)
- e_in  in  1  E pad level (asynchronous)
- d_out  out  1  D drive value
- d_oe  out  1  D output enable
- e_out  out  1  E drive value
- e_oe  out  1  E output enable
- light  in  1  stimulus; high while light is incident (synchronous to clock)
- cfg_word  out  15  last committed configuration word
- cfg_valid  out  1  one-cycle pulse on commit
- frame_err  out  1  one-cycle pulse on a malformed frame
- state  out  3  encoded FSM state, for debug

Behaviour:
Input conditioning:
- d_in and e_in each pass through a 2-flop synchronizer.
- Edges are detected against a third registered copy.
- Pad edge to FSM action latency: 3 cycles.
- All outputs are registered.

Reset (reset=0 at a clock edge):
- state=OFF, d_oe=e_oe=0, d_out=e_out=1.
- cfg_word=DEFAULT_CFG, cfg_valid=0, frame_err=0.
- Counters are cleared.
- Overrides everything, including a frame in progress.

chip_rst_n=0:
- Forces OFF from any state on the next edge.
- Outputs released; cfg_word reloads DEFAULT_CFG; no frame_err.

State encoding:
- OFF=0, POWERUP=1, CFG_IDLE=2, RX=3, TX=4, WAIT_STOP=5, WATCH=6.

OFF:
- Exits to POWERUP when chip_rst_n=1.

POWERUP:
- d_oe=1, d_out=~light, e_oe=0.
- Counts rising edges of light.
- On the falling edge of light that completes pulse number LIGHT_SWAPS: d_oe=0, go to CFG_IDLE.
- The master therefore sees exactly LIGHT_SWAPS high-to-low D transitions.

CFG_IDLE:
- Bus released (d_oe=e_oe=0).
- Start condition = D falls while E=1 → RX, bit_cnt=0, shift register cleared.
- A D rise while E=1 without a preceding start is ignored.

RX:
- Samples D on every E rising edge, MSB first.
- Bit 0 is the R/W bit (1=write, 0=read). Bits 1..15 are data.
- If bit 0 = 0: go to TX once the E rising edge that sampled it is seen.
- Stop condition = D rises while E=1:
  - bit_cnt=0: go to WATCH.
  - bit_cnt=16 with R/W=1: cfg_word←data, cfg_valid pulse, go to CFG_IDLE.
  - any other count: frame_err pulse, go to CFG_IDLE, cfg_word unchanged.
- A new start (D falls while E=1) mid-frame: frame_err pulse, restart RX with bit_cnt=0.
- A 17th E rising edge before stop: frame_err pulse, go to WAIT_STOP.

TX (read-back):
- On each E falling edge: d_oe=1, d_out=cfg_word[14-k] for k=0..14.
- The bit is held through the following E rising edge.
- On the E falling edge after the 15th rising edge: d_oe=0, go to WAIT_STOP.

WAIT_STOP:
- Bus released; stop → CFG_IDLE.
- Start → RX, with frame_err only if entered on error.

WATCH:
- d_oe=e_oe=1, e_out=~light, d_out=~light, each registered with 1-cycle latency.
- Left only via chip_rst_n=0 or reset.

Simultaneity:
- If a start and an E edge are detected in the same cycle, the start wins.
- cfg_valid and frame_err are never both asserted in the same cycle.

Test Plan:
1. reset=0 for 2 cycles, then chip_rst_n=1 and 4 light pulses of 20 cycles each → D shows 4 low pulses, d_oe falls after the 4th, state=2, cfg_word=15'h0000.
2. Write frame: start, R/W=1, data 15'h392B, stop → single cfg_valid pulse, cfg_word=15'h392B, frame_err=0.
3. Read frame after scenario 2: start, R/W=0, 15 E clocks with D released → master samples 011_1001_0010_1011 on the E rising edges, d_oe drops after the 15th, stop returns state=2.
4. Write frame stopped after 9 bits → frame_err pulse, cfg_word stays 15'h392B; a second start mid-frame also pulses frame_err and restarts cleanly.
5. Start immediately followed by stop → state=6, e_oe=d_oe=1; a 50-cycle light pulse gives e_out low for 50 cycles, lagging by 1 cycle.
6. chip_rst_n=0 during TX and in WATCH → outputs released next cycle, state=0, cfg_word=DEFAULT_CFG; reset=0 mid-RX gives the full reset values.

Source files
------------

// File: rtl/ts4231_bus_responder.sv
// TS4231 light-sensor emulation on the D/E configuration bus.
// Echoes power-up light pulses, accepts config writes, serves read-back, then watches.
module ts4231_bus_responder #(
    parameter logic [14:0] DEFAULT_CFG = 15'h0000,
    parameter int unsigned LIGHT_SWAPS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chip_rst_n,
    input  logic        d_in,
    input  logic        e_in,
    output logic        d_out,
    output logic        d_oe,
    output logic        e_out,
    output logic        e_oe,
    input  logic        light,
    output logic [14:0] cfg_word,
    output logic        cfg_valid,
    output logic        frame_err,
    output logic [2:0]  state
);

    localparam logic [2:0] S_OFF       = 3'd0;
    localparam logic [2:0] S_POWERUP   = 3'd1;
    localparam logic [2:0] S_CFG_IDLE  = 3'd2;
    localparam logic [2:0] S_RX        = 3'd3;
    localparam logic [2:0] S_TX        = 3'd4;
    localparam logic [2:0] S_WAIT_STOP = 3'd5;
    localparam logic [2:0] S_WATCH     = 3'd6;

    localparam logic [7:0] SWAPS = 8'(LIGHT_SWAPS);

    logic [2:0]  state_q, state_d;
    logic [2:0]  d_sync_q, e_sync_q;
    logic        light_q;
    logic [7:0]  light_cnt_q, light_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] sr_q, sr_d;
    logic        err_q, err_d;
    logic [14:0] cfg_q, cfg_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        e_out_q, e_out_d;
    logic        e_oe_q, e_oe_d;

    logic d_lvl, e_lvl, d_rise, d_fall, e_rise, e_fall;
    logic start_c, stop_c, light_rise, light_fall;

    // Stage [1] is the synchronized level, stage [2] the edge reference.
    assign d_lvl      = d_sync_q[1];
    assign e_lvl      = e_sync_q[1];
    assign d_rise     = d_sync_q[1] & ~d_sync_q[2];
    assign d_fall     = ~d_sync_q[1] & d_sync_q[2];
    assign e_rise     = e_sync_q[1] & ~e_sync_q[2];
    assign e_fall     = ~e_sync_q[1] & e_sync_q[2];
    assign start_c    = d_fall & e_lvl;
    assign stop_c     = d_rise & e_lvl;
    assign light_rise = light & ~light_q;
    assign light_fall = ~light & light_q;

    always_comb begin
        state_d     = state_q;
        light_cnt_d = light_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        err_d       = err_q;
        cfg_d       = cfg_q;
        cfg_valid_d = 1'b0;
        frame_err_d = 1'b0;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        e_out_d     = e_out_q;
        e_oe_d      = e_oe_q;

        case (state_q)
            S_OFF: begin
                d_oe_d      = 1'b0;
                e_oe_d      = 1'b0;
                d_out_d     = 1'b1;
                e_out_d     = 1'b1;
                light_cnt_d = '0;
                bit_cnt_d   = '0;
                state_d     = S_POWERUP;
            end
            S_POWERUP: begin
                d_oe_d  = 1'b1;
                d_out_d = ~light;
                e_oe_d  = 1'b0;
                if (light_rise)
                    light_cnt_d = light_cnt_q + 8'd1;
                if (light_fall && light_cnt_q == SWAPS) begin
                    d_oe_d  = 1'b0;
                    d_out_d = 1'b1;
                    state_d = S_CFG_IDLE;
                end
            end
            S_CFG_IDLE: begin
                d_oe_d = 1'b0;
                e_oe_d = 1'b0;
                if (start_c) begin
                    state_d   = S_RX;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                end
            end
            S_RX: begin
                // Start beats stop, stop beats a coincident E rise.
                if (start_c) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    sr_d        = '0;
                end else if (stop_c) begin
                    state_d = S_CFG_IDLE;
                    if (bit_cnt_q == 5'd0) begin
                        state_d = S_WATCH;
                    end else if (bit_cnt_q == 5'd16 && sr_q[15]) begin
                        cfg_d       = sr_q[14:0];
                        cfg_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (e_rise) begin
                    if (bit_cnt_q == 5'd16) begin
                        frame_err_d = 1'b1;
                        err_d       = 1'b1;
                        state_d     = S_WAIT_STOP;
                    end else if (bit_cnt_q == 5'd0 && !d_lvl) begin
                        bit_cnt_d = '0;
                        state_d   = S_TX;
                    end else begin
                        sr_d      = {sr_q[14:0], d_lvl};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_TX: begin
                if (e_fall) begin
                    if (bit_cnt_q == 5'd15) begin
                        d_oe_d  = 1'b0;
                        d_out_d = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_WAIT_STOP;
                    end else begin
                        d_oe_d  = 1'b1;
                        d_out_d = cfg_q[4'd14 - bit_cnt_q[3:0]];
                    end
                end else if (e_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            S_WAIT_STOP: begin
                d_oe_d = 1'b0;
                e_oe_d = 1'b0;
                if (start_c) begin
                    frame_err_d = err_q;
                    err_d       = 1'b0;
                    bit_cnt_d   = '0;
                    sr_d        = '0;
                    state_d     = S_RX;
                end else if (stop_c) begin
                    err_d   = 1'b0;
                    state_d = S_CFG_IDLE;
                end
            end
            S_WATCH: begin
                d_oe_d  = 1'b1;
                e_oe_d  = 1'b1;
                d_out_d = ~light;
                e_out_d = ~light;
            end
            default: state_d = S_OFF;
        endcase

        if (!chip_rst_n) begin
            state_d     = S_OFF;
            light_cnt_d = '0;
            bit_cnt_d   = '0;
            sr_d        = '0;
            err_d       = 1'b0;
            cfg_d       = DEFAULT_CFG;
            cfg_valid_d = 1'b0;
            frame_err_d = 1'b0;
            d_out_d     = 1'b1;
            d_oe_d      = 1'b0;
            e_out_d     = 1'b1;
            e_oe_d      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_OFF;
            d_sync_q    <= 3'b111;
            e_sync_q    <= 3'b111;
            light_q     <= 1'b0;
            light_cnt_q <= '0;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            err_q       <= 1'b0;
            cfg_q       <= DEFAULT_CFG;
            cfg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            d_out_q     <= 1'b1;
            d_oe_q      <= 1'b0;
            e_out_q     <= 1'b1;
            e_oe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_sync_q    <= {d_sync_q[1:0], d_in};
            e_sync_q    <= {e_sync_q[1:0], e_in};
            light_q     <= light;
            light_cnt_q <= light_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            err_q       <= err_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            frame_err_q <= frame_err_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            e_out_q     <= e_out_d;
            e_oe_q      <= e_oe_d;
        end
    end

    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;
    assign e_out     = e_out_q;
    assign e_oe      = e_oe_q;
    assign cfg_word  = cfg_q;
    assign cfg_valid = cfg_valid_q;
    assign frame_err = frame_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ts4231_bus_responder.sv
// Bench for ts4231_bus_responder: a D/E master model drives randomized frames
// and compares against a word-level model of the sensor configuration.
module tb_ts4231_bus_responder;

    localparam logic [14:0] DEF = 15'h0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        chip_rst_n = 1'b0;
    logic        light = 1'b0;
    logic        m_d = 1'b1;
    logic        m_e = 1'b1;
    logic        d_out, d_oe, e_out, e_oe;
    logic        cfg_valid, frame_err;
    logic [14:0] cfg_word;
    logic [2:0]  state;
    logic        d_pad, e_pad;

    int checks = 0;
    int failures = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    int exp_valid = 0, exp_err = 0;
    logic [14:0] cfg_model = DEF;

    assign d_pad = d_oe ? d_out : m_d;
    assign e_pad = e_oe ? e_out : m_e;

    always #5 clock = ~clock;

    ts4231_bus_responder dut (
        .clock      (clock),
        .reset      (reset),
        .chip_rst_n (chip_rst_n),
        .d_in       (d_pad),
        .e_in       (e_pad),
        .d_out      (d_out),
        .d_oe       (d_oe),
        .e_out      (e_out),
        .e_oe       (e_oe),
        .light      (light),
        .cfg_word   (cfg_word),
        .cfg_valid  (cfg_valid),
        .frame_err  (frame_err),
        .state      (state)
    );

    always @(negedge clock) begin
        if (cfg_valid) n_valid++;
        if (frame_err) n_err++;
        if (cfg_valid && frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic phase();
        cyc(int'($urandom_range(6, 9)));
    endtask

    task automatic m_start();
        m_d = 1'b0;
        phase();
    endtask

    task automatic m_bit(input logic b);
        m_e = 1'b0;
        phase();
        m_d = b;
        phase();
        m_e = 1'b1;
        phase();
    endtask

    task automatic m_bits(input logic [15:0] fr, input int n);
        for (int i = 0; i < n; i++) m_bit(fr[15-i]);
    endtask

    task automatic m_stop();
        m_e = 1'b0;
        phase();
        m_d = 1'b0;
        phase();
        m_e = 1'b1;
        m_d = 1'b1;
        phase();
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_valid"}, n_valid, exp_valid);
        check({tag, "_err"}, n_err, exp_err);
        check({tag, "_cfg"}, cfg_word, cfg_model);
        check({tag, "_state"}, state, 3'd2);
    endtask

    task automatic do_write(input logic [14:0] data);
        m_start();
        m_bits({1'b1, data}, 16);
        m_stop();
        exp_valid++;
        cfg_model = data;
    endtask

    task automatic do_read(input string tag);
        logic [14:0] rd;
        rd = '0;
        m_start();
        m_bit(1'b0);
        for (int k = 0; k < 15; k++) begin
            m_e = 1'b0;
            phase();
            rd[14-k] = d_pad;
            m_e = 1'b1;
            phase();
        end
        m_e = 1'b0;
        phase();
        check({tag, "_rd_oe"}, d_oe, 1'b0);
        check({tag, "_rd_ws"}, state, 3'd5);
        m_stop();
        check({tag, "_rd_word"}, rd, cfg_model);
    endtask

    task automatic powerup(input string tag);
        int falls;
        logic prev;
        chip_rst_n = 1'b1;
        m_d = 1'b1;
        m_e = 1'b1;
        light = 1'b0;
        cyc(3);
        prev = d_pad;
        falls = 0;
        for (int p = 0; p < 4; p++) begin
            light = 1'b1;
            for (int i = 0; i < 20; i++) begin
                cyc(1);
                if (prev && !d_pad) falls++;
                prev = d_pad;
            end
            light = 1'b0;
            for (int i = 0; i < int'($urandom_range(10, 20)); i++) begin
                cyc(1);
                if (prev && !d_pad) falls++;
                prev = d_pad;
            end
        end
        check({tag, "_falls"}, falls, 4);
        check({tag, "_doe"}, d_oe, 1'b0);
        check({tag, "_state"}, state, 3'd2);
        check({tag, "_cfg"}, cfg_word, cfg_model);
    endtask

    task automatic chip_reset(input string tag);
        chip_rst_n = 1'b0;
        cyc(1);
        check({tag, "_state"}, state, 3'd0);
        check({tag, "_doe"}, d_oe, 1'b0);
        check({tag, "_eoe"}, e_oe, 1'b0);
        check({tag, "_cfg"}, cfg_word, DEF);
        m_e = 1'b1;
        m_d = 1'b1;
        light = 1'b0;
        cyc(2);
        cfg_model = DEF;
    endtask

    initial begin
        logic [14:0] data;
        int n, low, lagbad;

        // Scenario 1: reset values and power-up light echo.
        reset = 1'b0;
        chip_rst_n = 1'b0;
        cyc(2);
        check("rst_state", state, 3'd0);
        check("rst_doe", d_oe, 1'b0);
        check("rst_eoe", e_oe, 1'b0);
        check("rst_dout", d_out, 1'b1);
        check("rst_eout", e_out, 1'b1);
        check("rst_cfg", cfg_word, DEF);
        check("rst_pulses", {cfg_valid, frame_err}, 2'b00);
        reset = 1'b1;
        cyc(1);
        powerup("pu1");

        // Scenario 2 and 3: fixed write then read-back.
        do_write(15'h392B);
        idle_chk("wr392b");
        check("wr392b_word", cfg_word, 15'h392B);
        do_read("rd392b");
        idle_chk("rd392b");

        // Scenario 4: short frame, then a restart mid-frame.
        m_start();
        m_bits({1'b1, 15'h5A5A}, 9);
        m_stop();
        exp_err++;
        idle_chk("short9");
        check("short9_keep", cfg_word, 15'h392B);
        m_start();
        m_bits({1'b1, 15'h1234}, 4);
        m_bit(1'b1);
        m_start();
        exp_err++;
        m_bits({1'b1, 15'h6C01}, 16);
        m_stop();
        exp_valid++;
        cfg_model = 15'h6C01;
        idle_chk("restart");

        // Randomized frame mix against the word-level model.
        for (int f = 0; f < 16; f++) begin
            data = 15'($urandom());
            case ($urandom_range(0, 4))
                0: do_write(data);
                1: do_read("rnd");
                2: begin
                    n = int'($urandom_range(1, 15));
                    m_start();
                    m_bits({1'b1, data}, n);
                    m_stop();
                    exp_err++;
                end
                3: begin
                    m_start();
                    m_bits({1'b1, data}, 16);
                    m_bit(1'b1);
                    exp_err++;
                    m_start();
                    exp_err++;
                    data = ~data;
                    m_bits({1'b1, data}, 16);
                    m_stop();
                    exp_valid++;
                    cfg_model = data;
                end
                default: begin
                    n = int'($urandom_range(1, 14));
                    m_start();
                    m_bits({1'b1, ~data}, n);
                    m_bit(1'b1);
                    m_start();
                    exp_err++;
                    do_write_tail(data);
                end
            endcase
            idle_chk("rnd");
        end

        // Scenario 6a: chip reset in the middle of a read-back.
        do_write(15'h7E81);
        m_start();
        m_bit(1'b0);
        for (int k = 0; k < 4; k++) begin
            m_e = 1'b0;
            phase();
            m_e = 1'b1;
            phase();
        end
        check("tx_state", state, 3'd4);
        chip_reset("crst_tx");
        powerup("pu2");

        // Scenario 5: start then stop enters watch.
        m_start();
        m_d = 1'b1;
        phase();
        check("watch_state", state, 3'd6);
        check("watch_oe", {d_oe, e_oe}, 2'b11);
        low = 0;
        lagbad = 0;
        for (int i = 0; i < 70; i++) begin
            light = (i >= 5 && i < 55);
            cyc(1);
            if (e_out === 1'b0) low++;
            if (e_out !== ~light || d_out !== ~light) lagbad++;
        end
        check("watch_low", low, 50);
        check("watch_lag", lagbad, 0);

        // Scenario 6b: chip reset in watch, then reset mid-frame.
        chip_reset("crst_watch");
        powerup("pu3");
        do_write(15'h2C3D);
        idle_chk("pre_rst");
        m_start();
        m_bits({1'b1, 15'h7FFF}, 5);
        reset = 1'b0;
        cyc(1);
        check("hrst_state", state, 3'd0);
        check("hrst_oe", {d_oe, e_oe}, 2'b00);
        check("hrst_out", {d_out, e_out}, 2'b11);
        check("hrst_cfg", cfg_word, DEF);
        check("hrst_pulses", {cfg_valid, frame_err}, 2'b00);
        check("never_both", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic do_write_tail(input logic [14:0] data);
        m_bits({1'b1, data}, 16);
        m_stop();
        exp_valid++;
        cfg_model = data;
    endtask

endmodule
